// File: rtl/axil_timer_if.sv
// AXI-Lite bus bundle for the machine timer slave.
// master drives requests; slave returns ready/response channels.
interface axil_timer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_timer.sv
// AXI-Lite RISC-V style 64-bit machine timer (mtime/mtimecmp) with a
// prescaler and a registered level interrupt.
module axil_timer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  axil_timer_if.slave s_axil,
  output logic       timer_irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_MTIME_LO = 3'd2;
  localparam logic [2:0] REG_MTIME_HI = 3'd3;
  localparam logic [2:0] REG_CMP_LO   = 3'd4;
  localparam logic [2:0] REG_CMP_HI   = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;
  localparam logic [2:0] REG_UNMAPPED = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = PRESCALE_WIDTH'(1);

  logic                      en;
  logic                      ie;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic [63:0]               mtime;
  logic [63:0]               mtimecmp;
  logic [31:0]               hi_shadow;
  logic                      bvalid;
  logic [1:0]                bresp;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      irq;

  logic                      en_next;
  logic                      ie_next;
  logic [PRESCALE_WIDTH-1:0] prescale_next;
  logic [PRESCALE_WIDTH-1:0] cnt_next;
  logic [63:0]               mtime_next;
  logic [63:0]               cmp_next;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic [1:0]                rd_resp;

  logic       wr_fire;
  logic       rd_fire;
  logic [2:0] wr_idx;
  logic [2:0] rd_idx;
  logic       tick;
  logic       cmp_hit;
  logic [63:0] mtime_ticked;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return merged;
  endfunction

  // Ready outputs are gated by rst so they drop the moment reset asserts.
  assign wr_fire = s_axil.awvalid & s_axil.wvalid & ~bvalid & ~rst;
  assign rd_fire = s_axil.arvalid & ~rvalid & ~rst;

  assign s_axil.awready = wr_fire;
  assign s_axil.wready  = wr_fire;
  assign s_axil.arready = ~rvalid & ~rst;
  assign s_axil.bvalid  = bvalid;
  assign s_axil.bresp   = bresp;
  assign s_axil.rvalid  = rvalid;
  assign s_axil.rdata   = rdata;
  assign s_axil.rresp   = rresp;
  assign timer_irq      = irq;

  assign wr_idx = s_axil.awaddr[4:2];
  assign rd_idx = s_axil.araddr[4:2];

  assign unused_addr_bits = ^{s_axil.awaddr[ADDR_WIDTH-1:5], s_axil.awaddr[1:0],
                              s_axil.araddr[ADDR_WIDTH-1:5], s_axil.araddr[1:0]};

  assign tick         = en & (presc_cnt == prescale);
  assign mtime_ticked = mtime + {63'd0, tick};
  assign cmp_hit      = (mtime >= mtimecmp);

  // Software writes override only the strobed bytes of the already-ticked value.
  always_comb begin
    en_next       = en;
    ie_next       = ie;
    prescale_next = prescale;
    mtime_next    = mtime_ticked;
    cmp_next      = mtimecmp;
    if (en) begin
      cnt_next = tick ? '0 : presc_cnt + CNT_ONE;
    end else begin
      cnt_next = presc_cnt;
    end

    if (wr_fire) begin
      case (wr_idx)
        REG_CTRL: begin
          if (s_axil.wstrb[0]) begin
            en_next = s_axil.wdata[0];
            ie_next = s_axil.wdata[1];
          end
          cnt_next = '0;
        end
        REG_PRESCALE: begin
          for (int b = 0; b < PRESCALE_WIDTH; b++) begin
            if (s_axil.wstrb[b/8]) begin
              prescale_next[b] = s_axil.wdata[b];
            end
          end
          cnt_next = '0;
        end
        REG_MTIME_LO: mtime_next[31:0]  = merge_bytes(mtime_ticked[31:0],  s_axil.wdata, s_axil.wstrb);
        REG_MTIME_HI: mtime_next[63:32] = merge_bytes(mtime_ticked[63:32], s_axil.wdata, s_axil.wstrb);
        REG_CMP_LO:   cmp_next[31:0]    = merge_bytes(mtimecmp[31:0],      s_axil.wdata, s_axil.wstrb);
        REG_CMP_HI:   cmp_next[63:32]   = merge_bytes(mtimecmp[63:32],     s_axil.wdata, s_axil.wstrb);
        default: ;
      endcase
    end
  end

  // Read mux samples pre-write state; MTIME_HI returns the shadow captured by the last LO read.
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      REG_CTRL:     rd_word = {30'd0, ie, en};
      REG_PRESCALE: rd_word = 32'(prescale);
      REG_MTIME_LO: rd_word = mtime[31:0];
      REG_MTIME_HI: rd_word = hi_shadow;
      REG_CMP_LO:   rd_word = mtimecmp[31:0];
      REG_CMP_HI:   rd_word = mtimecmp[63:32];
      REG_STATUS:   rd_word = {31'd0, cmp_hit};
      REG_UNMAPPED: rd_resp = RESP_SLVERR;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      prescale  <= '0;
      presc_cnt <= '0;
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq       <= 1'b0;
    end else begin
      en        <= en_next;
      ie        <= ie_next;
      prescale  <= prescale_next;
      presc_cnt <= cnt_next;
      mtime     <= mtime_next;
      mtimecmp  <= cmp_next;
      irq       <= ie & cmp_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (wr_fire) begin
      bvalid <= 1'b1;
      bresp  <= (wr_idx == REG_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid && s_axil.bready) begin
      bvalid <= 1'b0;
    end
  end

  // rdata/rresp only load on an AR handshake so they stay stable while rvalid waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      hi_shadow <= 32'd0;
    end else if (rd_fire) begin
      rvalid <= 1'b1;
      rdata  <= rd_word;
      rresp  <= rd_resp;
      if (rd_idx == REG_MTIME_LO) begin
        hi_shadow <= mtime[63:32];
      end
    end else if (rvalid && s_axil.rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_timer.sv
// Directed self-checking bench for axil_timer: register map, counting,
// interrupt latency, shadow reads, strobes, errors and handshake stalls.
module tb_axil_timer;

  localparam int TIMEOUT = 50;

  localparam logic [15:0] A_CTRL     = 16'h00;
  localparam logic [15:0] A_PRESCALE = 16'h04;
  localparam logic [15:0] A_MTIME_LO = 16'h08;
  localparam logic [15:0] A_MTIME_HI = 16'h0C;
  localparam logic [15:0] A_CMP_LO   = 16'h10;
  localparam logic [15:0] A_CMP_HI   = 16'h14;
  localparam logic [15:0] A_STATUS   = 16'h18;
  localparam logic [15:0] A_UNMAPPED = 16'h1C;

  logic clk;
  logic rst;
  logic timer_irq;
  int   checks;
  int   errors;

  axil_timer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  axil_timer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_axil   (bus.slave),
    .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic irq_at_b);
    int n;
    @(negedge clk);
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    #1;
    n = 0;
    while (!bus.awready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_output("aw_timeout", 64'(n >= TIMEOUT), 64'd0);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    @(negedge clk);
    n = 0;
    while (!bus.bvalid && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_output("b_timeout", 64'(n >= TIMEOUT), 64'd0);
    resp     = bus.bresp;
    irq_at_b = timer_irq;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_read(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_output("ar_timeout", 64'(n >= TIMEOUT), 64'd0);
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!bus.rvalid && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_output("r_timeout", 64'(n >= TIMEOUT), 64'd0);
    data = bus.rdata;
    resp = bus.rresp;
    @(posedge clk);
    #1;
  endtask

  task automatic write_ok(input string tag, input logic [15:0] addr, input logic [31:0] data);
    logic [1:0] resp;
    logic       irq_b;
    apply_write(addr, data, 4'hF, resp, irq_b);
    check_output(tag, 64'(resp), 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rd2;
    logic [1:0]  resp;
    logic        irq_b;
    int          n;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset defaults
    apply_read(A_CMP_LO, rd, resp);
    check_output("rst_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
    check_output("rst_cmp_lo_resp", 64'(resp), 64'd0);
    apply_read(A_CMP_HI, rd, resp);
    check_output("rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
    apply_read(A_CTRL, rd, resp);
    check_output("rst_ctrl", 64'(rd), 64'd0);
    check_output("rst_irq", 64'(timer_irq), 64'd0);

    // Count rate with PRESCALE=3: one tick per four cycles
    write_ok("wr_prescale3", A_PRESCALE, 32'd3);
    write_ok("wr_ctrl_en", A_CTRL, 32'd1);
    repeat (40) @(negedge clk);
    apply_read(A_MTIME_LO, rd, resp);
    check_output("rate_prescale3", 64'(rd >= 32'd9 && rd <= 32'd11), 64'd1);

    // PRESCALE=0: back-to-back LO reads are two cycles apart
    write_ok("wr_prescale0", A_PRESCALE, 32'd0);
    apply_read(A_MTIME_LO, rd, resp);
    apply_read(A_MTIME_LO, rd2, resp);
    check_output("rate_prescale0", 64'(rd2 - rd), 64'd2);

    // Interrupt rises one cycle after mtime reaches 20
    write_ok("wr_ctrl_off", A_CTRL, 32'd0);
    write_ok("wr_mtime_lo0", A_MTIME_LO, 32'd0);
    write_ok("wr_mtime_hi0", A_MTIME_HI, 32'd0);
    write_ok("wr_cmp_hi0", A_CMP_HI, 32'd0);
    write_ok("wr_cmp_lo20", A_CMP_LO, 32'd20);
    apply_write(A_CTRL, 32'd3, 4'hF, resp, irq_b);
    check_output("irq_low_at_start", 64'(irq_b), 64'd0);
    repeat (20) @(negedge clk);
    check_output("irq_before_edge", 64'(timer_irq), 64'd0);
    @(negedge clk);
    check_output("irq_rise", 64'(timer_irq), 64'd1);

    // Raising mtimecmp drops the interrupt one cycle after the write
    apply_write(A_CMP_LO, 32'd1000, 4'hF, resp, irq_b);
    check_output("irq_still_high", 64'(irq_b), 64'd1);
    check_output("irq_fall", 64'(timer_irq), 64'd0);

    // IE=0 masks the interrupt while STATUS reports the match
    write_ok("wr_ctrl_en_only", A_CTRL, 32'd1);
    write_ok("wr_cmp_lo5", A_CMP_LO, 32'd5);
    repeat (3) @(negedge clk);
    check_output("irq_masked", 64'(timer_irq), 64'd0);
    apply_read(A_STATUS, rd, resp);
    check_output("status_hit", 64'(rd), 64'd1);

    // Carry into the high word and the coherent shadow read
    write_ok("wr_ctrl_off2", A_CTRL, 32'd0);
    write_ok("wr_mtime_hi_c", A_MTIME_HI, 32'd0);
    write_ok("wr_mtime_lo_c", A_MTIME_LO, 32'hFFFF_FFFE);
    write_ok("wr_ctrl_en2", A_CTRL, 32'd1);
    apply_read(A_MTIME_LO, rd, resp);
    check_output("carry_lo1", 64'(rd), 64'hFFFF_FFFF);
    apply_read(A_MTIME_HI, rd, resp);
    check_output("carry_hi_shadow0", 64'(rd), 64'd0);
    apply_read(A_MTIME_LO, rd, resp);
    check_output("carry_lo2", 64'(rd), 64'd3);
    apply_read(A_MTIME_HI, rd, resp);
    check_output("carry_hi_shadow1", 64'(rd), 64'd1);

    // Full 64-bit wrap
    write_ok("wr_ctrl_off3", A_CTRL, 32'd0);
    write_ok("wr_mtime_hi_w", A_MTIME_HI, 32'hFFFF_FFFF);
    write_ok("wr_mtime_lo_w", A_MTIME_LO, 32'hFFFF_FFFF);
    write_ok("wr_ctrl_en3", A_CTRL, 32'd1);
    apply_read(A_MTIME_LO, rd, resp);
    check_output("wrap_lo", 64'(rd), 64'd0);
    apply_read(A_MTIME_HI, rd, resp);
    check_output("wrap_hi", 64'(rd), 64'd0);

    // Byte strobes
    write_ok("wr_cmp_lo_base", A_CMP_LO, 32'h1122_3344);
    apply_write(A_CMP_LO, 32'hAABB_CCDD, 4'b0010, resp, irq_b);
    apply_read(A_CMP_LO, rd, resp);
    check_output("strobe_byte1", 64'(rd), 64'h1122_CC44);

    // Unmapped offset and read-only STATUS
    apply_read(A_UNMAPPED, rd, resp);
    check_output("slverr_rresp", 64'(resp), 64'd2);
    check_output("slverr_rdata", 64'(rd), 64'd0);
    apply_write(A_UNMAPPED, 32'h1234_5678, 4'hF, resp, irq_b);
    check_output("slverr_bresp", 64'(resp), 64'd2);
    write_ok("status_wr_okay", A_STATUS, 32'hFFFF_FFFF);
    apply_read(A_STATUS, rd, resp);
    check_output("status_unchanged", 64'(rd), 64'd0);
    apply_read(A_CTRL, rd, resp);
    check_output("ctrl_after_status_wr", 64'(rd), 64'd1);

    // bready held low: bvalid holds and a second write waits
    @(negedge clk);
    bus.awaddr = A_CMP_LO; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    #1;
    n = 0;
    while (!bus.awready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_output("stall_aw_timeout", 64'(n >= TIMEOUT), 64'd0);
    @(posedge clk);
    #1;
    bus.wdata = 32'h66;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall_bvalid", 64'(bus.bvalid), 64'd1);
      check_output("stall_awready", 64'(bus.awready), 64'd0);
      check_output("stall_bresp", 64'(bus.bresp), 64'd0);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    #1;
    check_output("aw_after_b", 64'(bus.awready), 64'd1);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    @(negedge clk);
    check_output("second_bvalid", 64'(bus.bvalid), 64'd1);
    @(posedge clk);
    #1;
    apply_read(A_CMP_LO, rd, resp);
    check_output("second_write_data", 64'(rd), 64'h66);

    // rready held low: rvalid and rdata hold, no new AR accepted
    @(negedge clk);
    bus.araddr = A_CMP_LO; bus.arvalid = 1'b1; bus.rready = 1'b0;
    #1;
    @(posedge clk);
    #1;
    bus.araddr = A_CTRL;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("rstall_rvalid", 64'(bus.rvalid), 64'd1);
      check_output("rstall_rdata", 64'(bus.rdata), 64'h66);
      check_output("rstall_arready", 64'(bus.arready), 64'd0);
    end
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    @(posedge clk);
    #1;
    check_output("rstall_release", 64'(bus.rvalid), 64'd0);

    // AW without W waits for W
    @(negedge clk);
    bus.awaddr = A_PRESCALE; bus.wdata = 32'd7; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b0; bus.bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("aw_only_wait", 64'(bus.awready), 64'd0);
    end
    bus.wvalid = 1'b1;
    #1;
    check_output("aw_w_ready", 64'(bus.awready), 64'd1);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    apply_read(A_PRESCALE, rd, resp);
    check_output("aw_w_data", 64'(rd), 64'd7);

    // Reset in the middle of a read, with the interrupt active
    write_ok("wr_cmp_hi_r", A_CMP_HI, 32'd0);
    write_ok("wr_cmp_lo_r", A_CMP_LO, 32'd0);
    write_ok("wr_ctrl_ie", A_CTRL, 32'd3);
    repeat (2) @(negedge clk);
    check_output("irq_before_rst", 64'(timer_irq), 64'd1);
    @(negedge clk);
    bus.araddr = A_CMP_LO; bus.arvalid = 1'b1; bus.rready = 1'b0;
    #1;
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check_output("rvalid_before_rst", 64'(bus.rvalid), 64'd1);
    rst = 1'b1;
    #1;
    check_output("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check_output("rst_arready", 64'(bus.arready), 64'd0);
    check_output("rst_irq_drop", 64'(timer_irq), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.rready = 1'b1;
    apply_read(A_CMP_LO, rd, resp);
    check_output("rst2_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
    apply_read(A_CTRL, rd, resp);
    check_output("rst2_ctrl", 64'(rd), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
